// File: rtl/tone_gen_if.sv
// Control/status bundle for one tone_gen voice: burst parameters and trigger/stop in,
// busy/done/sample out. The voice sits on the slave side.
interface tone_gen_if #(
    parameter int WIDTH = 24,
    parameter int PER_W = 20,
    parameter int DUR_W = 24
);
    logic [PER_W-1:0] period;
    logic [WIDTH-1:0] amplitude;
    logic [DUR_W-1:0] duration;
    logic             trigger;
    logic             stop;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (
        output period, amplitude, duration, trigger, stop,
        input  busy, done, out
    );

    modport slave (
        input  period, amplitude, duration, trigger, stop,
        output busy, done, out
    );
endinterface

// File: rtl/tone_gen.sv
// Triggerable square-wave tone generator: programmable half-period, level, burst length, polarity.
// Optional exponential decay is compiled in with `define TONE_GEN_DECAY_EN.
module tone_gen #(
    parameter int WIDTH     = 24,
    parameter int PER_W     = 20,
    parameter int DUR_W     = 24,
    parameter int SIGNED    = 0,
    parameter int DECAY_CYC = 1000000
) (
    input  logic      CLOCK_50,
    input  logic      reset,
    tone_gen_if.slave tg
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_reg, state_next;
    logic [PER_W-1:0] per_q, per_next;
    logic [WIDTH-1:0] amp_q, amp_next;
    logic [DUR_W-1:0] dur_q, dur_next;
    logic [PER_W-1:0] ph_cnt, ph_cnt_next;
    logic [DUR_W-1:0] dur_cnt, dur_cnt_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] out_reg, out_next;

    if (DECAY_CYC < 1) begin : g_bad_cfg
        $error("tone_gen: DECAY_CYC must be at least 1");
    end

`ifdef TONE_GEN_DECAY_EN
    localparam int DC_W = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;
    logic [DC_W-1:0] dc_cnt, dc_cnt_next;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) dc_cnt <= '0;
        else       dc_cnt <= dc_cnt_next;
    end
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            per_q     <= '0;
            amp_q     <= '0;
            dur_q     <= '0;
            ph_cnt    <= '0;
            dur_cnt   <= '0;
            done_reg  <= 1'b0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            per_q     <= per_next;
            amp_q     <= amp_next;
            dur_q     <= dur_next;
            ph_cnt    <= ph_cnt_next;
            dur_cnt   <= dur_cnt_next;
            done_reg  <= done_next;
            out_reg   <= out_next;
        end
    end

    // Priority: trigger (restart) > stop (silent abort) > natural end > phase toggle.
    always_comb begin
        state_next   = state_reg;
        per_next     = per_q;
        amp_next     = amp_q;
        dur_next     = dur_q;
        ph_cnt_next  = ph_cnt;
        dur_cnt_next = dur_cnt;
        done_next    = 1'b0;
        out_next     = '0;
`ifdef TONE_GEN_DECAY_EN
        dc_cnt_next  = dc_cnt;
`endif
        if (tg.trigger) begin
            state_next   = HIGH;
            per_next     = (tg.period == '0) ? PER_W'(1) : tg.period;
            amp_next     = tg.amplitude;
            dur_next     = tg.duration;
            ph_cnt_next  = '0;
            dur_cnt_next = '0;
`ifdef TONE_GEN_DECAY_EN
            dc_cnt_next  = '0;
`endif
        end else if (state_reg != IDLE) begin
            if (tg.stop) begin
                state_next = IDLE;
            end else begin
                dur_cnt_next = dur_cnt + 1'b1;
                if (ph_cnt == per_q - 1'b1) begin
                    ph_cnt_next = '0;
                    state_next  = (state_reg == HIGH) ? LOW : HIGH;
                end else begin
                    ph_cnt_next = ph_cnt + 1'b1;
                end
`ifdef TONE_GEN_DECAY_EN
                if (dc_cnt == DC_W'(DECAY_CYC - 1)) begin
                    dc_cnt_next = '0;
                    amp_next    = amp_q >> 1;
                end else begin
                    dc_cnt_next = dc_cnt + 1'b1;
                end
                // A fully decayed voice is treated as a natural burst end.
                if (amp_next == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
`endif
                // Duration end overrides any coincident toggle; the counter freezes here.
                if ((dur_q != '0) && (dur_cnt == dur_q - 1'b1)) begin
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    dur_cnt_next = dur_cnt;
                end
            end
        end

        case (state_next)
            HIGH:    out_next = amp_next;
            LOW:     out_next = (SIGNED != 0) ? (-amp_next) : '0;
            default: out_next = '0;
        endcase
    end

    assign tg.busy = (state_reg != IDLE);
    assign tg.done = done_reg;
    assign tg.out  = out_reg;
endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: hand-written cycle table, asynchronous-reset sequences and a
// randomized run checked against a burst-time reference model. Two voices (SIGNED=0/1).
module tb_tone_gen;
    localparam int WIDTH = 24;
    localparam int PER_W = 20;
    localparam int DUR_W = 24;
    localparam int DC    = 8;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    tone_gen_if #(.WIDTH(WIDTH), .PER_W(PER_W), .DUR_W(DUR_W)) bus_u ();
    tone_gen_if #(.WIDTH(WIDTH), .PER_W(PER_W), .DUR_W(DUR_W)) bus_s ();

    tone_gen #(.WIDTH(WIDTH), .PER_W(PER_W), .DUR_W(DUR_W), .SIGNED(0), .DECAY_CYC(DC)) u_dut_u (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tg       (bus_u)
    );
    tone_gen #(.WIDTH(WIDTH), .PER_W(PER_W), .DUR_W(DUR_W), .SIGNED(1), .DECAY_CYC(DC)) u_dut_s (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tg       (bus_s)
    );

    typedef struct {
        bit          trig;
        bit          stp;
        int unsigned per;
        int unsigned amp;
        int unsigned dur;
        bit          e_busy;
        bit          e_done;
        int unsigned e_out_u;
        int unsigned e_out_s;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position inside the current burst, in clocks since the trigger edge.
    bit          m_active = 0;
    bit          m_done   = 0;
    int          m_t      = 0;
    int          m_p      = 1;
    logic [23:0] m_a      = '0;
    int unsigned m_d      = 0;

    function automatic logic [23:0] amp_at(logic [23:0] a, int t);
`ifdef TONE_GEN_DECAY_EN
        return a >> (t / DC);
`else
        return a;
`endif
    endfunction

    function automatic logic [23:0] model_out(bit sgn);
        logic [23:0] lvl;
        if (!m_active) return '0;
        lvl = amp_at(m_a, m_t);
        if (((m_t / m_p) % 2) == 0) return lvl;
        return sgn ? 24'(-lvl) : 24'h0;
    endfunction

    task automatic model_step(bit trig, bit stp, int unsigned per, logic [23:0] amp, int unsigned dur);
        bit decayed;
        m_done = 0;
        if (trig) begin
            m_active = 1; m_t = 0;
            m_p = (per == 0) ? 1 : int'(per);
            m_a = amp; m_d = dur;
        end else if (m_active && stp) begin
            m_active = 0;
        end else if (m_active) begin
            m_t++;
`ifdef TONE_GEN_DECAY_EN
            decayed = (amp_at(m_a, m_t) == 0);
`else
            decayed = 0;
`endif
            if ((m_d != 0 && m_t >= int'(m_d)) || decayed) begin
                m_active = 0;
                m_done   = 1;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(bit trig, bit stp, int unsigned per, int unsigned amp, int unsigned dur);
        bus_u.trigger = trig;       bus_s.trigger = trig;
        bus_u.stop = stp;           bus_s.stop = stp;
        bus_u.period = PER_W'(per); bus_s.period = PER_W'(per);
        bus_u.amplitude = 24'(amp); bus_s.amplitude = 24'(amp);
        bus_u.duration = 24'(dur);  bus_s.duration = 24'(dur);
    endtask

    task automatic chk_idle(string name);
        chk({name, "_busy_u"}, 32'(bus_u.busy), 0);
        chk({name, "_done_u"}, 32'(bus_u.done), 0);
        chk({name, "_out_u"},  32'(bus_u.out),  0);
        chk({name, "_busy_s"}, 32'(bus_s.busy), 0);
        chk({name, "_done_s"}, 32'(bus_s.done), 0);
        chk({name, "_out_s"},  32'(bus_s.out),  0);
    endtask

    task automatic chk_model(string name);
        chk({name, "_busy_u"}, 32'(bus_u.busy), 32'(m_active));
        chk({name, "_done_u"}, 32'(bus_u.done), 32'(m_done));
        chk({name, "_out_u"},  32'(bus_u.out),  32'(model_out(0)));
        chk({name, "_busy_s"}, 32'(bus_s.busy), 32'(m_active));
        chk({name, "_done_s"}, 32'(bus_s.done), 32'(m_done));
        chk({name, "_out_s"},  32'(bus_s.out),  32'(model_out(1)));
    endtask

    // One clock with stimulus applied at the falling edge, model advanced and checked after the rise.
    task automatic model_cycle(string name, bit trig, bit stp, int unsigned per, int unsigned amp, int unsigned dur);
        @(negedge CLOCK_50);
        drive(trig, stp, per, amp, dur);
        @(posedge CLOCK_50); #1;
        model_step(trig, stp, per, 24'(amp), dur);
        chk_model(name);
    endtask

    task automatic add(bit tr, bit st, int unsigned per, int unsigned amp, int unsigned dur,
                       bit eb, bit ed, int unsigned eu, int unsigned es);
        vec_t v;
        v.trig = tr; v.stp = st; v.per = per; v.amp = amp; v.dur = dur;
        v.e_busy = eb; v.e_done = ed; v.e_out_u = eu; v.e_out_s = es;
        vecs.push_back(v);
    endtask

    task automatic add_run(int n, bit eb, int unsigned eu, int unsigned es);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, eb, 0, eu, es);
    endtask

    // Async reset between edges, hold through one edge, release, confirm the voice stays idle.
    task automatic async_reset_seq(string name);
        #3 reset = 1'b1;
        #1 chk_idle({name, "_async"});
        @(posedge CLOCK_50); #1;
        chk_idle({name, "_held"});
        @(negedge CLOCK_50);
        reset = 1'b0;
        drive(0, 0, 2, 24'h00ABCD, 0);
        @(posedge CLOCK_50); #1;
        chk_idle({name, "_after"});
        m_active = 0; m_done = 0;
        $display("async reset %s checked", name);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
`ifndef TONE_GEN_DECAY_EN
        // period 4, continuous
        add(1, 0, 4, 24'h00E000, 0, 1, 0, 24'h00E000, 24'h00E000);
        add_run(3, 1, 24'h00E000, 24'h00E000);
        add_run(4, 1, 0, 24'hFF2000);
        add_run(1, 1, 24'h00E000, 24'h00E000);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // period 3, duration 10
        add(1, 0, 3, 24'h005555, 10, 1, 0, 24'h005555, 24'h005555);
        add_run(2, 1, 24'h005555, 24'h005555);
        add_run(3, 1, 0, 24'hFFAAAB);
        add_run(3, 1, 24'h005555, 24'h005555);
        add_run(1, 1, 0, 24'hFFAAAB);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        add_run(2, 0, 0, 0);
        // period 2, signed low level
        add(1, 0, 2, 24'h000100, 0, 1, 0, 24'h000100, 24'h000100);
        add_run(1, 1, 24'h000100, 24'h000100);
        add_run(2, 1, 0, 24'hFFFF00);
        add_run(2, 1, 24'h000100, 24'h000100);
        add_run(1, 1, 0, 24'hFFFF00);
        // retrigger on the 5th clock of a period-4 burst
        add(1, 0, 4, 24'h000010, 0, 1, 0, 24'h000010, 24'h000010);
        add_run(3, 1, 24'h000010, 24'h000010);
        add(1, 0, 2, 24'h000020, 0, 1, 0, 24'h000020, 24'h000020);
        add_run(1, 1, 24'h000020, 24'h000020);
        add_run(2, 1, 0, 24'hFFFFE0);
        add_run(1, 1, 24'h000020, 24'h000020);
        // stop and trigger together, period 0 -> 1, duration 3
        add(1, 1, 0, 24'h000030, 3, 1, 0, 24'h000030, 24'h000030);
        add_run(1, 1, 0, 24'hFFFFD0);
        add_run(1, 1, 24'h000030, 24'h000030);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // duration end coinciding with a toggle
        add(1, 0, 3, 24'h000007, 6, 1, 0, 24'h000007, 24'h000007);
        add_run(2, 1, 24'h000007, 24'h000007);
        add_run(3, 1, 0, 24'hFFFFF9);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        // one-clock burst
        add(1, 0, 1, 24'h000009, 1, 1, 0, 24'h000009, 24'h000009);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        add_run(1, 0, 0, 0);
`else
        begin
            int unsigned lvl[3] = '{4, 2, 1};
            add(1, 0, 2, 24'h000004, 0, 1, 0, 4, 4);
            for (int t = 1; t < 24; t++) begin
                if ((t % 4) < 2) add_run(1, 1, lvl[t / 8], lvl[t / 8]);
                else             add_run(1, 1, 0, 32'h01000000 - lvl[t / 8]);
            end
            add(0, 0, 0, 0, 0, 0, 1, 0, 0);
            add_run(2, 0, 0, 0);
        end
`endif

        // reset state
        @(posedge CLOCK_50); #1;
        chk_idle("reset");
        @(negedge CLOCK_50);
        reset = 1'b0;
        drive(0, 1, 3, 24'h123456, 5);
        @(posedge CLOCK_50); #1;
        chk_idle("stop_idle");

        foreach (vecs[i]) begin
            @(negedge CLOCK_50);
            if (vecs[i].trig) drive(1, vecs[i].stp, vecs[i].per, vecs[i].amp, vecs[i].dur);
            else drive(0, vecs[i].stp, $urandom_range(0, 9), $urandom, $urandom_range(0, 40));
            @(posedge CLOCK_50); #1;
            chk($sformatf("row%0d_busy_u", i), 32'(bus_u.busy), 32'(vecs[i].e_busy));
            chk($sformatf("row%0d_done_u", i), 32'(bus_u.done), 32'(vecs[i].e_done));
            chk($sformatf("row%0d_out_u", i),  32'(bus_u.out),  vecs[i].e_out_u);
            chk($sformatf("row%0d_busy_s", i), 32'(bus_s.busy), 32'(vecs[i].e_busy));
            chk($sformatf("row%0d_done_s", i), 32'(bus_s.done), 32'(vecs[i].e_done));
            chk($sformatf("row%0d_out_s", i),  32'(bus_s.out),  vecs[i].e_out_s);
            $display("row %0d trig=%0b stop=%0b busy=%0b done=%0b out=%h/%h",
                     i, vecs[i].trig, vecs[i].stp, bus_u.busy, bus_u.done, bus_u.out, bus_s.out);
        end

        // reset mid-burst, then reset during a done pulse
        m_active = 0; m_done = 0;
        model_cycle("pre_rst", 1, 0, 3, 24'h00C0DE, 0);
        model_cycle("pre_rst", 0, 0, 7, 24'h000001, 0);
        async_reset_seq("mid_burst");
        model_cycle("pre_rst2", 1, 0, 5, 24'h000777, 2);
        model_cycle("pre_rst2", 0, 0, 0, 0, 0);
        model_cycle("pre_rst2", 0, 0, 0, 0, 0);
        chk("done_before_rst", 32'(bus_u.done), 1);
        async_reset_seq("on_done");
        model_cycle("resume", 1, 0, 2, 24'h000042, 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bit          tr  = ($urandom_range(0, 19) == 0);
            bit          st  = ($urandom_range(0, 29) == 0);
            int unsigned per = $urandom_range(0, 5);
            int unsigned amp = $urandom & 32'h00FFFFFF;
            int unsigned dur = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 25);
            model_cycle($sformatf("rnd%0d", c), tr, st, per, amp, dur);
            if (tr) $display("burst @%0d: period=%0d amp=%h dur=%0d stop=%0b", c, per, amp, dur, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
